// File: rtl/syn_fifo_lvl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syn_fifo_lvl_pkg : read-mode constants, clog2 helper, legality check macro |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

`ifndef SYN_FIFO_LVL_PARAMS_OK
`define SYN_FIFO_LVL_PARAMS_OK(D, AF, AE) \
    (((D) >= 2) && ((((D) & ((D) - 1))) == 0) && \
     ((AF) >= 1) && ((AF) <= (D)) && ((AE) >= 0) && ((AE) <= ((D) - 1)))
`endif

package syn_fifo_lvl_pkg;

    localparam int FIFO_REG  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/syn_fifo_lvl_mem_2p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_mem_2p : register array, sync write, comb read, optional output reg   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module fifo_mem_2p
    import syn_fifo_lvl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int REG_OUT = 1,
    parameter int ADDR_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [WIDTH-1:0]  r_data
);

    // Storage is intentionally left out of reset.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (r_en) begin
                    data_q <= mem[r_addr];
                end
            end

            assign r_data = data_q;
        end else begin : g_comb_out
            logic unused_ok;

            assign unused_ok = ^{r_en, rst_n};
            assign r_data    = mem[r_addr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/syn_fifo_lvl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syn_fifo_lvl : single-clock FIFO with level, almost flags, REG/FWFT read.  |
// | Optional sticky overflow/underflow via macro SYN_FIFO_LVL_ERR_EN.          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module syn_fifo_lvl
    import syn_fifo_lvl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SYN_FIFO_LVL_ERR_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    input  logic [WIDTH-1:0]  w_data,
    input  logic              w_request,
    input  logic              r_request,
    output logic [WIDTH-1:0]  r_data,
    output logic              full_status,
    output logic              empty_status,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level
);

    generate
        if (!(`SYN_FIFO_LVL_PARAMS_OK(DEPTH, AF_THRESH, AE_THRESH)) ||
            ((FWFT != FIFO_REG) && (FWFT != FIFO_FWFT))) begin : g_param_fatal
            $fatal(1, "syn_fifo_lvl: illegal DEPTH/AF_THRESH/AE_THRESH/FWFT");
        end
    endgenerate

    localparam logic [ADDR_W:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0] LVL_FULL  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LVL_AF    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] LVL_AE    = AE_THRESH[ADDR_W:0];
    localparam int              MEM_REG   = (FWFT == FIFO_REG) ? 1 : 0;

    logic [ADDR_W:0]  w_ptr;
    logic [ADDR_W:0]  r_ptr;
    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] mem_rdata;

    // Status is a pure decode of the pointer flops; requests never reach it.
    assign level        = w_ptr - r_ptr;
    assign full_status  = (level == LVL_FULL);
    assign empty_status = (level == '0);
    assign almost_full  = (level >= LVL_AF);
    assign almost_empty = (level <= LVL_AE);

    assign w_en = w_request & ~full_status;
    assign r_en = r_request & ~empty_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (w_en) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (r_en) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    fifo_mem_2p #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .REG_OUT (MEM_REG),
        .ADDR_W  (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_en   (w_en),
        .w_addr (w_ptr[ADDR_W-1:0]),
        .w_data (w_data),
        .r_en   (r_en),
        .r_addr (r_ptr[ADDR_W-1:0]),
        .r_data (mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign r_data = empty_status ? '0 : mem_rdata;
        end else begin : g_reg
            assign r_data = mem_rdata;
        end
    endgenerate

`ifdef SYN_FIFO_LVL_ERR_EN
    // A new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~err_clr) | (w_request & full_status);
            underflow <= (underflow & ~err_clr) | (r_request & empty_status);
        end
    end
`endif

endmodule

`default_nettype wire
